// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg : shared constants, pointer state and helpers for the timer block
// Revision  : 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

  localparam logic [1:0] ADDR_C0  = 2'b00;
  localparam logic [1:0] ADDR_C1  = 2'b01;
  localparam logic [1:0] ADDR_C2  = 2'b10;
  localparam logic [1:0] ADDR_CWR = 2'b11;

  localparam logic [1:0] RW_LATCH   = 2'b00;
  localparam logic [1:0] RW_LSB     = 2'b01;
  localparam logic [1:0] RW_MSB     = 2'b10;
  localparam logic [1:0] RW_LSB_MSB = 2'b11;

  localparam int MODE_W = 3;

  typedef enum logic {
    PTR_LSB = 1'b0,
    PTR_MSB = 1'b1
  } ptr_t;

  // Modes 6 and 7 alias onto 2 and 3.
  function automatic logic [MODE_W-1:0] norm_mode(input logic [MODE_W-1:0] m);
    return (m[2] && m[1]) ? {1'b0, m[1:0]} : m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_access_ctrl.sv
// ============================================================================
// counter_access_ctrl : one counter's programming state, byte pointers, strobes
// Revision            : 1.0
// ============================================================================
`default_nettype none

module counter_access_ctrl
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cw_load,
  input  logic              cw_latch,
  input  logic [1:0]        cw_rw,
  input  logic [MODE_W-1:0] cw_mode,
  input  logic              cw_bcd,
  input  logic              wr_start,
  input  logic              rd_end,
  output logic [MODE_W-1:0] mode,
  output logic              bcd,
  output logic [1:0]        rw_fmt,
  output logic              cw_new,
  output logic              latch,
  output logic              wr_lsb,
  output logic              wr_msb,
  output logic              wr_done,
  output logic              rd_msb
);

  ptr_t wr_ptr;
  ptr_t rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= '0;
      bcd     <= 1'b0;
      rw_fmt  <= RW_LSB;
      wr_ptr  <= PTR_LSB;
      rd_ptr  <= PTR_LSB;
      cw_new  <= 1'b0;
      latch   <= 1'b0;
      wr_lsb  <= 1'b0;
      wr_msb  <= 1'b0;
      wr_done <= 1'b0;
    end else begin
      cw_new  <= 1'b0;
      latch   <= 1'b0;
      wr_lsb  <= 1'b0;
      wr_msb  <= 1'b0;
      wr_done <= 1'b0;

      if (cw_load) begin
        rw_fmt <= cw_rw;
        mode   <= norm_mode(cw_mode);
        bcd    <= cw_bcd;
        wr_ptr <= PTR_LSB;
        rd_ptr <= PTR_LSB;
        cw_new <= 1'b1;
      end

      if (cw_latch) begin
        latch <= 1'b1;
      end

      if (wr_start) begin
        case (rw_fmt)
          RW_LSB: begin
            wr_lsb  <= 1'b1;
            wr_done <= 1'b1;
          end
          RW_MSB: begin
            wr_msb  <= 1'b1;
            wr_done <= 1'b1;
          end
          RW_LSB_MSB: begin
            if (wr_ptr == PTR_LSB) begin
              wr_lsb <= 1'b1;
              wr_ptr <= PTR_MSB;
            end else begin
              wr_msb  <= 1'b1;
              wr_done <= 1'b1;
              wr_ptr  <= PTR_LSB;
            end
          end
          default: ;
        endcase
      end

      // Read pointer only advances once the read access has finished.
      if (rd_end && (rw_fmt == RW_LSB_MSB)) begin
        rd_ptr <= (rd_ptr == PTR_LSB) ? PTR_MSB : PTR_LSB;
      end
    end
  end

  assign rd_msb = (rw_fmt == RW_MSB) || ((rw_fmt == RW_LSB_MSB) && (rd_ptr == PTR_MSB));

endmodule

`default_nettype wire

// File: rtl/control_word_logic.sv
// ============================================================================
// control_word_logic : access edge detection, control-word decode, counter select
// Revision           : 1.0
// ============================================================================
`default_nettype none

module control_word_logic
  import timer_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [1:0]             Add_bus,
  input  logic                   RW_bus,
  input  logic                   Access,
  input  logic [7:0]             D_in,
  output logic [2:0][MODE_W-1:0] Mode,
  output logic [2:0]             Bcd,
  output logic [2:0][1:0]        Rw_fmt,
  output logic [2:0]             Cw_new,
  output logic [2:0]             Latch,
  output logic [7:0]             Wr_data,
  output logic [2:0]             Wr_lsb,
  output logic [2:0]             Wr_msb,
  output logic [2:0]             Wr_done,
  output logic [2:0]             Rd_msb
);

  logic       acc_q;
  logic       rd_q;
  logic [1:0] addr_q;
  logic       start_ev;
  logic       end_ev;
  logic       cw_ev;

  assign start_ev = Access && !acc_q;
  assign end_ev   = !Access && acc_q;
  assign cw_ev    = start_ev && !RW_bus && (Add_bus == ADDR_CWR) && (D_in[7:6] != 2'b11);

  // acc_q resets high so an access spanning reset release is never seen as a start.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q   <= 1'b1;
      rd_q    <= 1'b0;
      addr_q  <= ADDR_C0;
      Wr_data <= 8'h00;
    end else begin
      acc_q <= Access;
      if (start_ev) begin
        rd_q   <= RW_bus;
        addr_q <= Add_bus;
        if (!RW_bus && (Add_bus != ADDR_CWR)) begin
          Wr_data <= D_in;
        end
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_counter
    localparam logic [1:0] ADDR = (i == 0) ? ADDR_C0 : (i == 1) ? ADDR_C1 : ADDR_C2;

    logic sel_cw;
    logic cw_load;
    logic cw_latch;
    logic wr_start;
    logic rd_end;

    assign sel_cw   = cw_ev && (D_in[7:6] == ADDR);
    assign cw_load  = sel_cw && (D_in[5:4] != RW_LATCH);
    assign cw_latch = sel_cw && (D_in[5:4] == RW_LATCH);
    assign wr_start = start_ev && !RW_bus && (Add_bus == ADDR);
    assign rd_end   = end_ev && rd_q && (addr_q == ADDR);

    counter_access_ctrl u_ctrl (
      .clk      (CLK),
      .rst      (RESET),
      .cw_load  (cw_load),
      .cw_latch (cw_latch),
      .cw_rw    (D_in[5:4]),
      .cw_mode  (D_in[3:1]),
      .cw_bcd   (D_in[0]),
      .wr_start (wr_start),
      .rd_end   (rd_end),
      .mode     (Mode[i]),
      .bcd      (Bcd[i]),
      .rw_fmt   (Rw_fmt[i]),
      .cw_new   (Cw_new[i]),
      .latch    (Latch[i]),
      .wr_lsb   (Wr_lsb[i]),
      .wr_msb   (Wr_msb[i]),
      .wr_done  (Wr_done[i]),
      .rd_msb   (Rd_msb[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_control_word_logic.sv
// ============================================================================
// tb_control_word_logic : scoreboard bench for control_word_logic
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_control_word_logic;

  logic             clk;
  logic             rst;
  logic [1:0]       add_bus;
  logic             rw_bus;
  logic             access;
  logic [7:0]       d_in;
  logic [2:0][2:0]  mode;
  logic [2:0]       bcd;
  logic [2:0][1:0]  rw_fmt;
  logic [2:0]       cw_new;
  logic [2:0]       latch;
  logic [7:0]       wr_data;
  logic [2:0]       wr_lsb;
  logic [2:0]       wr_msb;
  logic [2:0]       wr_done;
  logic [2:0]       rd_msb;

  control_word_logic dut (
    .CLK     (clk),
    .RESET   (rst),
    .Add_bus (add_bus),
    .RW_bus  (rw_bus),
    .Access  (access),
    .D_in    (d_in),
    .Mode    (mode),
    .Bcd     (bcd),
    .Rw_fmt  (rw_fmt),
    .Cw_new  (cw_new),
    .Latch   (latch),
    .Wr_data (wr_data),
    .Wr_lsb  (wr_lsb),
    .Wr_msb  (wr_msb),
    .Wr_done (wr_done),
    .Rd_msb  (rd_msb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [63:0] v;
  } exp_t;

  exp_t sbq[$];

  // Independent reference model of the programming state and strobes
  logic [2:0] m_mode [3];
  logic       m_bcd  [3];
  logic [1:0] m_fmt  [3];
  logic       m_wptr [3];
  logic       m_rptr [3];
  logic [2:0] m_lsb, m_msb, m_done, m_cwn, m_lat;
  logic [7:0] m_wd;
  logic       m_acc, m_rd;
  logic [1:0] m_addr;

  function automatic logic [63:0] pack_dut();
    return 64'({mode, bcd, rw_fmt, cw_new, latch, wr_data, wr_lsb, wr_msb, wr_done, rd_msb});
  endfunction

  function automatic logic [63:0] pack_model();
    logic [2:0] rm;
    for (int k = 0; k < 3; k++)
      rm[k] = (m_fmt[k] == 2'd2) || (m_fmt[k] == 2'd3 && m_rptr[k]);
    return 64'({m_mode[2], m_mode[1], m_mode[0],
                m_bcd[2], m_bcd[1], m_bcd[0],
                m_fmt[2], m_fmt[1], m_fmt[0],
                m_cwn, m_lat, m_wd, m_lsb, m_msb, m_done, rm});
  endfunction

  task automatic model_step(input string tag);
    logic st, en;
    int   sc, idx;
    logic [2:0] m;
    exp_t e;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        m_mode[k] = 0; m_bcd[k] = 0; m_fmt[k] = 2'd1; m_wptr[k] = 0; m_rptr[k] = 0;
      end
      {m_lsb, m_msb, m_done, m_cwn, m_lat} = '0;
      m_wd = 8'h00; m_acc = 1'b1; m_rd = 1'b0; m_addr = 2'd0;
    end else begin
      {m_lsb, m_msb, m_done, m_cwn, m_lat} = '0;
      st = access && !m_acc;
      en = !access && m_acc;
      if (st && !rw_bus) begin
        if (add_bus == 2'd3) begin
          sc = int'(d_in[7:6]);
          if (sc != 3) begin
            if (d_in[5:4] == 2'd0) m_lat[sc] = 1'b1;
            else begin
              m = d_in[3:1];
              if (m >= 3'd6) m = m - 3'd4;
              m_fmt[sc] = d_in[5:4]; m_mode[sc] = m; m_bcd[sc] = d_in[0];
              m_wptr[sc] = 0; m_rptr[sc] = 0; m_cwn[sc] = 1'b1;
            end
          end
        end else begin
          idx = int'(add_bus);
          m_wd = d_in;
          if (m_fmt[idx] == 2'd1) begin m_lsb[idx] = 1; m_done[idx] = 1; end
          else if (m_fmt[idx] == 2'd2) begin m_msb[idx] = 1; m_done[idx] = 1; end
          else if (!m_wptr[idx]) begin m_lsb[idx] = 1; m_wptr[idx] = 1; end
          else begin m_msb[idx] = 1; m_done[idx] = 1; m_wptr[idx] = 0; end
        end
      end
      if (en && m_rd && m_addr != 2'd3 && m_fmt[m_addr] == 2'd3)
        m_rptr[m_addr] = !m_rptr[m_addr];
      if (st) begin m_rd = rw_bus; m_addr = add_bus; end
      m_acc = access;
    end
    e.tag = tag;
    e.v   = pack_model();
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check(e.tag, pack_dut(), e.v);
    end
  end

  task automatic tick(input string tag);
    @(posedge clk);
    model_step(tag);
    #1;
    if (|{cw_new, latch, wr_lsb, wr_msb, wr_done}) pulses++;
  endtask

  task automatic do_access(input logic rw, input logic [1:0] addr, input logic [7:0] d,
                           input int len, input string tag);
    access = 1'b1; rw_bus = rw; add_bus = addr; d_in = d;
    for (int k = 0; k < len; k++) tick(tag);
    access = 1'b0;
    tick(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; access = 1'b0; rw_bus = 1'b0; add_bus = 2'd0; d_in = 8'h00;
    repeat (3) tick("reset");
    check("reset_values", pack_dut(), 64'({9'd0, 3'd0, 6'b010101, 26'd0}));
    rst = 1'b0;
    tick("idle");

    // Unprogrammed counters default to LSB-only writes
    do_access(1'b0, 2'd0, 8'h00, 2, "wr_c0_default");
    do_access(1'b0, 2'd2, 8'h00, 2, "wr_c2_default");

    do_access(1'b0, 2'd3, 8'h36, 2, "cw_36");
    do_access(1'b0, 2'd0, 8'h34, 2, "wr_c0_lsb");
    do_access(1'b0, 2'd0, 8'h12, 2, "wr_c0_msb");
    check("mode0_is_3", 64'(mode[0]), 64'd3);
    check("wr_data_12", 64'(wr_data), 64'h12);

    do_access(1'b0, 2'd3, 8'h7C, 2, "cw_7c");
    check("mode1_alias", 64'(mode[1]), 64'd2);
    do_access(1'b1, 2'd1, 8'h00, 3, "rd_c1_first");
    check("rd_msb1_after_first", 64'(rd_msb[1]), 64'd1);
    do_access(1'b1, 2'd1, 8'h00, 3, "rd_c1_second");
    check("rd_msb1_after_second", 64'(rd_msb[1]), 64'd0);

    pulses = 0;
    do_access(1'b0, 2'd3, 8'h80, 3, "cw_latch_c2");
    check("latch_pulse_count", 64'(pulses), 64'd1);
    pulses = 0;
    do_access(1'b0, 2'd3, 8'hC2, 3, "cw_readback");
    check("readback_no_pulse", 64'(pulses), 64'd0);
    check("c2_fmt_kept", 64'(rw_fmt[2]), 64'd1);

    do_access(1'b0, 2'd3, 8'h36, 1, "cw_36_again");
    do_access(1'b0, 2'd0, 8'hAA, 1, "wr_c0_aa");
    do_access(1'b0, 2'd3, 8'h36, 1, "cw_36_abort");
    do_access(1'b0, 2'd0, 8'hBB, 1, "wr_c0_bb");

    // Access already active when reset releases must not register
    access = 1'b1; rw_bus = 1'b0; add_bus = 2'd0; d_in = 8'h55;
    rst = 1'b1;
    repeat (2) tick("reset_held");
    rst = 1'b0;
    pulses = 0;
    repeat (3) tick("access_over_reset");
    access = 1'b0;
    tick("access_over_reset");
    check("no_event_over_reset", 64'(pulses), 64'd0);

    pulses = 0;
    do_access(1'b0, 2'd0, 8'h77, 20, "long_write");
    check("long_write_one_set", 64'(pulses), 64'd1);
    check("long_write_data", 64'(wr_data), 64'h77);

    tick("drain");
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_word_logic.md
# control_word_logic

Synchronous access sequencer downstream of the chip's read/write logic. It consumes the address bus, the read/write bus and the data bus, and decodes control words written to address 11. It keeps the per-counter programming state (mode, BCD, RW format) and runs the per-counter LSB/MSB byte pointers. It emits one-cycle load, latch and new-control-word strobes to counters 0–2.

## Interface
- No parameters; counter count fixed at 3.
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- Add_bus  in  2  target: 00 C0, 01 C1, 10 C2, 11 CWR.
- RW_bus  in  1  1 = read, 0 = write; meaningful only while Access=1.
- Access  in  1  high for the whole duration of a valid (_CS=0, exactly one of _RD/_WR low) cycle.
- D_in  in  8  data bus, stable while Access=1.
- Mode  out  3×3  per-counter mode, 0–5.
- Bcd  out  3  per-counter BCD flag.
- Rw_fmt  out  3×2  per-counter RW format: 01 LSB, 10 MSB, 11 LSB-then-MSB.
- Cw_new  out  3  one-cycle pulse: counter i received a control word.
- Latch  out  3  one-cycle pulse: counter-latch command for counter i.
- Wr_data  out  8  registered data byte accompanying write strobes.
- Wr_lsb / Wr_msb  out  3 / 3  one-cycle pulse: load Wr_data into LSB / MSB of counter i.
- Wr_done  out  3  one-cycle pulse: count write for counter i complete.
- Rd_msb  out  3  level: counter i's current read returns MSB (0 = LSB).

## Operation
- Access events use a registered copy acc_q.
  - Start event: Access=1 and acc_q=0.
  - End event: Access=0 and acc_q=1.
- CWR write (start event, RW_bus=0, Add_bus=11): decode D_in as SC[7:6], RW[5:4], M[3:1], BCD[0].
  - SC=11 (read-back) is not supported. No state change and no strobe.
  - RW=00 is the latch command: pulse Latch[SC]. Mode, BCD and Rw_fmt are unchanged.
  - RW≠00: load Rw_fmt, Mode and Bcd for counter SC.
    - M=110 is stored as 010; M=111 is stored as 011.
    - Reset counter SC's write and read pointers to LSB.
    - Pulse Cw_new[SC].
- Counter write (start event, RW_bus=0, Add_bus=i≠11): register D_in into Wr_data.
  - Fmt 01: pulse Wr_lsb[i] and Wr_done[i].
  - Fmt 10: pulse Wr_msb[i] and Wr_done[i].
  - Fmt 11, pointer=LSB: pulse Wr_lsb[i]; pointer→MSB.
  - Fmt 11, pointer=MSB: pulse Wr_msb[i] and Wr_done[i]; pointer→LSB.
- Counter read: Rd_msb[i] selects the byte for the downstream mux for the whole access.
  - Fmt 01: Rd_msb[i]=0. Fmt 10: Rd_msb[i]=1.
  - Fmt 11: read pointer toggles on the end event of a read to counter i.
- Reads of CWR are ignored; no state change.
- Per-counter byte-pointer FSM: states LSB, MSB, with the transitions above. Write and read pointers are independent.

## Timing
- Start/end detection: event seen in cycle N → strobes high in cycle N+1 only. Mode/Bcd/Rw_fmt/pointers update at the same edge.
- Wr_data is valid in the same cycle as its Wr_lsb/Wr_msb strobe and holds until the next write.
- Each access produces at most one strobe set, regardless of access length.
- Reset values:
  - Mode=0, Bcd=0, Rw_fmt=01 for all counters.
  - All pointers LSB, Rd_msb=000.
  - All strobes 0, Wr_data=00.
  - acc_q=1.
- Because acc_q resets to 1, an access already in progress when RESET deasserts produces no event.
- Reset mid-sequence (e.g. LSB written, MSB pending): the sequence is abandoned; the next write is treated as LSB.
- A control word to counter i while its write pointer=MSB forces the pointer back to LSB. No Wr_done is issued.
- A control word to counter j does not affect counter i≠j.
- Back-to-back accesses with a one-cycle gap (Access low for 1 cycle) are both detected.

## Structure
- Shared package timer_pkg holds:
  - Address constants ADDR_C0/C1/C2/CWR.
  - RW-format encodings RW_LATCH/RW_LSB/RW_MSB/RW_LSB_MSB.
  - Mode width constant.
  - Pointer state enum PTR_LSB/PTR_MSB.
- Sub-module counter_access_ctrl, instantiated 3×, holds one counter's Mode/Bcd/Rw_fmt registers, write/read pointer FSMs and strobe generation.
- Top level does edge detection, address/control-word decode and per-counter select.

## Test plan
- Reset, then write 0x00 to counter 0 and 0x00 to counter 2 (no control word) → Wr_lsb pulse with Wr_done each time; Mode=0, Rw_fmt=01 unchanged.
- CWR write 0x36 (C0, LSB/MSB, mode 3), then writes 0x34, 0x12 to counter 0 → Cw_new[0]; Wr_lsb[0]+Wr_data=34; then Wr_msb[0]+Wr_done[0]+Wr_data=12; Mode[0]=3.
- CWR 0x7C (C1, LSB/MSB, M=110), two reads of counter 1 → Mode[1]=2; Rd_msb[1]=0 during the first read, 1 during the second, 0 after.
- CWR 0x80 (C2 latch) → Latch[2] single pulse; Mode/Rw_fmt of C2 unchanged. CWR 0xC2 → no strobes, no state change.
- After CWR 0x36, write 0xAA to C0, then CWR 0x36 again, then write 0xBB → second write gives Wr_lsb[0] with Wr_data=BB; no Wr_done.
- Hold Access high across RESET deassertion, then a 20-cycle write access → no strobes for the first access, exactly one strobe set for the second.
